// File: rtl/ysyx_22041071_booth2_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22041071_booth2_seq
//  Description : Iterative radix-4 Booth multiplier sequencer. Accepts one
//                64x64 multiply, walks 33 Booth digits (one per cycle),
//                drives the shifted multiplicand and digit selects to an
//                external partial-product generator, accumulates the returned
//                partial products into a 132-bit sum and hands the 128-bit
//                product to writeback over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22041071_booth2_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         mul_valid,
    output logic         mul_ready,
    input  logic [1:0]   mul_signed,
    input  logic         mulw,
    input  logic [63:0]  multiplicand,
    input  logic [63:0]  multiplier,
    output logic [131:0] pp_x,
    output logic         pp_sel_neg,
    output logic         pp_sel_pos,
    output logic         pp_sel_dou_neg,
    output logic         pp_sel_dou_pos,
    input  logic [131:0] pp_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  result_hi,
    output logic [63:0]  result_lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Index of the 33rd (final) Booth digit.
    localparam logic [5:0] c_LAST_DIGIT = 6'd32;

    // Select vector packing used internally: {neg, pos, dou_neg, dou_pos}.
    localparam logic [3:0] c_SEL_NONE    = 4'b0000;
    localparam logic [3:0] c_SEL_NEG     = 4'b1000;
    localparam logic [3:0] c_SEL_POS     = 4'b0100;
    localparam logic [3:0] c_SEL_DOU_NEG = 4'b0010;
    localparam logic [3:0] c_SEL_DOU_POS = 4'b0001;

    state_t         r_state;
    logic [131:0]   r_acc;
    logic [131:0]   r_x;
    logic [66:0]    r_y;
    logic [5:0]     r_cnt;
    logic [3:0]     r_sel;
    logic           r_mulw;

    logic           w_sign_a;
    logic           w_sign_b;
    logic [63:0]    w_a_prep;
    logic [63:0]    w_b_prep;
    logic [131:0]   w_x_init;
    logic [66:0]    w_y_init;
    logic [131:0]   w_acc_sum;
    logic [66:0]    w_y_shift;
    logic [63:0]    w_lo_final;

    // Radix-4 Booth recoding of one overlapping 3-bit window.
    function automatic logic [3:0] booth_sel(input logic [2:0] digit);
        case (digit)
            3'b001, 3'b010: booth_sel = c_SEL_POS;
            3'b011:         booth_sel = c_SEL_DOU_POS;
            3'b100:         booth_sel = c_SEL_DOU_NEG;
            3'b101, 3'b110: booth_sel = c_SEL_NEG;
            default:        booth_sel = c_SEL_NONE;
        endcase
    endfunction

    // Operand preparation: signedness decode (2'b01 folds to unsigned),
    // word-op narrowing and extension into the datapath widths.
    always_comb begin
        w_sign_a = mul_signed[1];
        w_sign_b = mul_signed[1] & mul_signed[0];

        if (mulw) begin
            w_a_prep = {{32{w_sign_a & multiplicand[31]}}, multiplicand[31:0]};
            w_b_prep = {{32{w_sign_b & multiplier[31]}},   multiplier[31:0]};
        end else begin
            w_a_prep = multiplicand;
            w_b_prep = multiplier;
        end

        w_x_init = {{68{w_sign_a & w_a_prep[63]}}, w_a_prep};
        w_y_init = {{2{w_sign_b & w_b_prep[63]}}, w_b_prep, 1'b0};
    end

    // Accumulator adder, multiplier shift and final low-word formatting.
    always_comb begin
        w_acc_sum  = r_acc + pp_result;
        w_y_shift  = {r_y[66], r_y[66], r_y[66:2]};
        w_lo_final = r_mulw ? {{32{w_acc_sum[31]}}, w_acc_sum[31:0]}
                            : w_acc_sum[63:0];
    end

    // Sequencer: IDLE -> BUSY (33 digits) -> DONE -> IDLE, with flush abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_cnt     <= '0;
            r_sel     <= c_SEL_NONE;
            r_mulw    <= 1'b0;
            mul_ready <= 1'b1;
            out_valid <= 1'b0;
            result_hi <= '0;
            result_lo <= '0;
        end else if (flush) begin
            // Kill wins over both accept and output handshake; acc left as is.
            r_state   <= S_IDLE;
            r_sel     <= c_SEL_NONE;
            mul_ready <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mul_valid) begin
                        r_state   <= S_BUSY;
                        r_x       <= w_x_init;
                        r_y       <= w_y_init;
                        r_acc     <= '0;
                        r_cnt     <= '0;
                        r_mulw    <= mulw;
                        // First digit window is {B'[1:0], 0}.
                        r_sel     <= booth_sel(w_y_init[2:0]);
                        mul_ready <= 1'b0;
                    end
                end

                S_BUSY: begin
                    r_acc <= w_acc_sum;
                    r_x   <= r_x << 2;
                    r_y   <= w_y_shift;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == c_LAST_DIGIT) begin
                        r_state   <= S_DONE;
                        r_sel     <= c_SEL_NONE;
                        out_valid <= 1'b1;
                        result_hi <= w_acc_sum[127:64];
                        result_lo <= w_lo_final;
                    end else begin
                        // Selects for the next digit come from the shifted window.
                        r_sel <= booth_sel(w_y_shift[2:0]);
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        r_state   <= S_IDLE;
                        out_valid <= 1'b0;
                        mul_ready <= 1'b1;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_sel     <= c_SEL_NONE;
                    out_valid <= 1'b0;
                    mul_ready <= 1'b1;
                end
            endcase
        end
    end

    assign pp_x           = r_x;
    assign pp_sel_neg     = r_sel[3];
    assign pp_sel_pos     = r_sel[2];
    assign pp_sel_dou_neg = r_sel[1];
    assign pp_sel_dou_pos = r_sel[0];

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22041071_booth2_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_22041071_booth2_seq
//  Description : Self-checking bench for the radix-4 Booth sequencer. Models
//                the partial-product generator, and compares every product
//                against a plain-arithmetic reference multiply.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22041071_booth2_seq;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         mul_valid;
    logic         mul_ready;
    logic [1:0]   mul_signed;
    logic         mulw;
    logic [63:0]  multiplicand;
    logic [63:0]  multiplier;
    logic [131:0] pp_x;
    logic         pp_sel_neg;
    logic         pp_sel_pos;
    logic         pp_sel_dou_neg;
    logic         pp_sel_dou_pos;
    logic [131:0] pp_result;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  result_hi;
    logic [63:0]  result_lo;

    int n_tests = 0;
    int n_fail  = 0;
    int sel_err = 0;

    ysyx_22041071_booth2_seq u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .mul_valid      (mul_valid),
        .mul_ready      (mul_ready),
        .mul_signed     (mul_signed),
        .mulw           (mulw),
        .multiplicand   (multiplicand),
        .multiplier     (multiplier),
        .pp_x           (pp_x),
        .pp_sel_neg     (pp_sel_neg),
        .pp_sel_pos     (pp_sel_pos),
        .pp_sel_dou_neg (pp_sel_dou_neg),
        .pp_sel_dou_pos (pp_sel_dou_pos),
        .pp_result      (pp_result),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .result_hi      (result_hi),
        .result_lo      (result_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Partial-product generator: {0, +X, +2X, -X, -2X} mod 2^132.
    always_comb begin
        pp_result = '0;
        if (pp_sel_pos)          pp_result = pp_x;
        else if (pp_sel_dou_pos) pp_result = pp_x << 1;
        else if (pp_sel_neg)     pp_result = '0 - pp_x;
        else if (pp_sel_dou_neg) pp_result = '0 - (pp_x << 1);
    end

    // Selects must be one-hot or all zero at every sample point.
    always @(negedge clk) begin
        if ((32'(pp_sel_neg) + 32'(pp_sel_pos) + 32'(pp_sel_dou_neg) + 32'(pp_sel_dou_pos)) > 1)
            sel_err++;
    end

    task automatic check(input string tag, input logic [131:0] got, input logic [131:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: extend prepared operands to 128 bits and multiply.
    function automatic logic [127:0] ref_mul(input logic [1:0] ms, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
        logic         sa, sb;
        logic [63:0]  ap, bp;
        logic [127:0] ea, eb, p;
        sa = ms[1];
        sb = (ms == 2'b11);
        ap = w ? (sa ? {{32{a[31]}}, a[31:0]} : {32'b0, a[31:0]}) : a;
        bp = w ? (sb ? {{32{b[31]}}, b[31:0]} : {32'b0, b[31:0]}) : b;
        ea = sa ? {{64{ap[63]}}, ap} : {64'b0, ap};
        eb = sb ? {{64{bp[63]}}, bp} : {64'b0, bp};
        p  = ea * eb;
        if (w) p[63:0] = {{32{p[31]}}, p[31:0]};
        return p;
    endfunction

    function automatic logic [63:0] pick_operand();
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0:       v = 64'hFFFF_FFFF_FFFF_FFFF;
            1:       v = 64'h8000_0000_0000_0000;
            2:       v = 64'(($urandom_range(0, 15)));
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    // Issue one op at a negedge, wait for the product, hold, then handshake.
    // Latency is counted in rising edges after the accept edge.
    task automatic run_op(input string tag, input logic [1:0] ms, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] ehi, input logic [63:0] elo, input int hold);
        int lat;
        check({tag, "_rdy_before"}, 132'(mul_ready), 132'd1);
        mul_valid = 1'b1;  mul_signed = ms;  mulw = w;
        multiplicand = a;  multiplier = b;
        @(negedge clk);
        check({tag, "_rdy_busy"}, 132'(mul_ready), 132'd0);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            // Requests while busy must be ignored.
            multiplicand = {$urandom, $urandom};
            multiplier   = {$urandom, $urandom};
            mul_signed   = 2'($urandom_range(0, 3));
            mulw         = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        mul_valid = 1'b0;
        check({tag, "_latency"}, 132'(lat), 132'd33);
        check({tag, "_hi"}, 132'(result_hi), 132'(ehi));
        check({tag, "_lo"}, 132'(result_lo), 132'(elo));
        check({tag, "_sel_done"}, 132'({pp_sel_neg, pp_sel_pos, pp_sel_dou_neg, pp_sel_dou_pos}), 132'd0);
        repeat (hold) @(negedge clk);
        if (hold > 0) begin
            check({tag, "_hold_hi"}, 132'(result_hi), 132'(ehi));
            check({tag, "_hold_lo"}, 132'(result_lo), 132'(elo));
            check({tag, "_hold_valid"}, 132'(out_valid), 132'd1);
            check({tag, "_hold_rdy"}, 132'(mul_ready), 132'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_after"}, 132'(out_valid), 132'd0);
    endtask

    initial begin
        logic [1:0]   ms;
        logic         w;
        logic [63:0]  a, b;
        logic [127:0] p;
        int           seen;

        rst_n = 1'b0;  flush = 1'b0;  mul_valid = 1'b0;  mul_signed = 2'b00;
        mulw = 1'b0;   multiplicand = '0;  multiplier = '0;  out_ready = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_ready", 132'(mul_ready), 132'd1);
        check("rst_valid", 132'(out_valid), 132'd0);
        check("rst_hi", 132'(result_hi), 132'd0);
        check("rst_lo", 132'(result_lo), 132'd0);
        check("rst_ppx", pp_x, 132'd0);
        check("rst_sel", 132'({pp_sel_neg, pp_sel_pos, pp_sel_dou_neg, pp_sel_dou_pos}), 132'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        run_op("u3x5",  2'b00, 1'b0, 64'd3, 64'd5, 64'd0, 64'hF, 0);
        run_op("sm1",   2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1, 0);
        run_op("smin",  2'b11, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
               64'h4000_0000_0000_0000, 64'd0, 0);
        run_op("umax",  2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 0);
        run_op("hsu",   2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
        run_op("illeg", 2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        run_op("mulw",  2'b11, 1'b1, 64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002,
               64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        // Long stall in DONE, then a back-to-back request right after handshake.
        run_op("stall", 2'b00, 1'b0, 64'd1000, 64'd1000, 64'd0, 64'd1000000, 10);
        run_op("b2b",   2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd9, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFEE, 0);

        // flush wins over accept in IDLE.
        mul_valid = 1'b1;  flush = 1'b1;  multiplicand = 64'd4;  multiplier = 64'd4;
        @(negedge clk);
        mul_valid = 1'b0;  flush = 1'b0;
        check("flush_vs_accept", 132'(mul_ready), 132'd1);

        // Flush at BUSY cycle 15.
        mul_valid = 1'b1;  mul_signed = 2'b00;  mulw = 1'b0;
        multiplicand = 64'd11;  multiplier = 64'd13;
        @(negedge clk);
        mul_valid = 1'b0;
        repeat (14) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_ready", 132'(mul_ready), 132'd1);
        check("flush_sel", 132'({pp_sel_neg, pp_sel_pos, pp_sel_dou_neg, pp_sel_dou_pos}), 132'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush_no_valid", 132'(seen), 132'd0);

        // Reset at cycle 20 of a second op.
        mul_valid = 1'b1;  mul_signed = 2'b11;
        multiplicand = 64'd21;  multiplier = 64'd22;
        @(negedge clk);
        mul_valid = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_ready", 132'(mul_ready), 132'd1);
        check("arst_ppx", pp_x, 132'd0);
        check("arst_sel", 132'({pp_sel_neg, pp_sel_pos, pp_sel_dou_neg, pp_sel_dou_pos}), 132'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("arst_no_valid", 132'(seen), 132'd0);
        check("arst_lo", 132'(result_lo), 132'd0);

        run_op("s7xm3", 2'b11, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB, 0);

        // Randomized ops against the reference multiply.
        for (int i = 0; i < 40; i++) begin
            ms = 2'($urandom_range(0, 3));
            w  = 1'($urandom_range(0, 3) == 0);
            a  = pick_operand();
            b  = pick_operand();
            p  = ref_mul(ms, w, a, b);
            run_op($sformatf("rnd%0d", i), ms, w, a, b, p[127:64], p[63:0], $urandom_range(0, 3));
        end

        check("sel_onehot", 132'(sel_err), 132'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
